// File: rtl/mp_mult_pkg.sv
// Shared types and sizing helpers for the sequential multi-precision multiplier.
package mp_mult_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  function automatic int cdiv(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  // Counter width for n distinct values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mp_mult_seq_if.sv
// Operand/result valid-ready bundle for mp_mult_seq.
interface mp_mult_seq_if #(parameter int A_W = 131, parameter int B_W = 128);
  localparam int P_W = A_W + B_W;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           acc_in;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] p;

  modport master (output in_valid, a, b, acc_in, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, acc_in, out_ready,
                  output in_ready, out_valid, p);
endinterface

// File: rtl/mp_limb_mul.sv
// Registered unsigned limb multiplier; shift/valid sideband travels with the product.
module mp_limb_mul #(
  parameter int LIMB_W = 66,
  parameter int SH_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [LIMB_W-1:0]     x,
  input  logic [LIMB_W-1:0]     y,
  input  logic [SH_W-1:0]       in_shift,
  output logic                  pp_valid,
  output logic [2*LIMB_W-1:0]   pp,
  output logic [SH_W-1:0]       pp_shift
);
  localparam int PP_W = 2 * LIMB_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_valid <= 1'b0;
      pp       <= '0;
      pp_shift <= '0;
    end else begin
      pp_valid <= in_vld;
      pp       <= PP_W'(x) * PP_W'(y);
      pp_shift <= in_shift;
    end
  end
endmodule

// File: rtl/mp_mult_seq.sv
// Sequential multi-precision (MAC-capable) multiplier: one limb product per cycle
// through a shared registered multiplier, shifted and summed into a P_W accumulator.
module mp_mult_seq
  import mp_mult_pkg::*;
#(
  parameter int A_W    = 131,
  parameter int B_W    = 128,
  parameter int LIMB_W = 66
) (
  input  logic clk,
  input  logic rst,
  mp_mult_seq_if.slave bus
);
  localparam int P_W   = A_W + B_W;
  localparam int NA    = cdiv(A_W, LIMB_W);
  localparam int NB    = cdiv(B_W, LIMB_W);
  localparam int N     = NA * NB;
  localparam int IDX_W = idx_w(N);
  localparam int IA_W  = idx_w(NA);
  localparam int IB_W  = idx_w(NB);
  localparam int SH_W  = idx_w((NA + NB - 2) * LIMB_W + 1);
  localparam int AX_W  = NA * LIMB_W;
  localparam int BX_W  = NB * LIMB_W;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx;
  logic [A_W-1:0]             a_q;
  logic [B_W-1:0]             b_q;
  logic [P_W-1:0]             acc, acc_sum, p_q;
  logic [NA-1:0][LIMB_W-1:0]  a_limbs;
  logic [NB-1:0][LIMB_W-1:0]  b_limbs;
  logic [IA_W-1:0]            li;
  logic [IB_W-1:0]            lj;
  logic [SH_W-1:0]            issue_shift, pp_shift;
  logic [2*LIMB_W-1:0]        pp;
  logic                       pp_valid;
  logic                       accept;

  assign accept        = (state_q == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

  // Zero-extended limb views; idx walks A limbs fastest.
  assign a_limbs     = AX_W'(a_q);
  assign b_limbs     = BX_W'(b_q);
  assign li          = IA_W'(32'(idx) % NA);
  assign lj          = IB_W'(32'(idx) / NA);
  assign issue_shift = SH_W'((32'(li) + 32'(lj)) * LIMB_W);

  mp_limb_mul #(.LIMB_W(LIMB_W), .SH_W(SH_W)) u_limb_mul (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (state_q == MUL),
    .x        (a_limbs[li]),
    .y        (b_limbs[lj]),
    .in_shift (issue_shift),
    .pp_valid (pp_valid),
    .pp       (pp),
    .pp_shift (pp_shift)
  );

  always_comb begin
    acc_sum = acc;
    if (pp_valid) acc_sum = acc + (P_W'(pp) << pp_shift);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = MUL;
      MUL:     if (idx == IDX_W'(N - 1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      p_q <= '0;
    end else begin
      acc <= acc_sum;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        idx <= '0;
        // MAC chains onto whatever p currently shows, consumed or not.
        acc <= bus.acc_in ? p_q : '0;
      end
      if (state_q == MUL)   idx <= idx + 1'b1;
      if (state_q == DRAIN) p_q <= acc_sum;
    end
  end
endmodule

// File: doc/mp_mult_seq.md
# mp_mult_seq

Parametrised sequential multi-precision multiplier with an optional multiply-accumulate mode. It splits both operands into LIMB_W-bit limbs and runs all limb products through one shared, registered LIMB_W×LIMB_W multiplier, one product per cycle. Results are accumulated with the correct shift. It sits in the accelerator datapath as the generalised replacement for the fixed 131×128 four-product multiplier, and uses valid/ready handshakes on both sides.

## Interface
- A_W, 131, width of operand a
- B_W, 128, width of operand b
- LIMB_W, 66, limb width; NA = ceil(A_W/LIMB_W), NB = ceil(B_W/LIMB_W), N = NA*NB
- P_W, A_W+B_W, result width (derived, not overridable)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands and acc_in are valid
- in_ready  output  1  block accepts operands (high only in IDLE)
- a  input  A_W  multiplicand, unsigned
- b  input  B_W  multiplier, unsigned
- acc_in  input  1  1: p_new = p_prev + a*b (mod 2^P_W); 0: p_new = a*b
- out_valid  output  1  p holds a completed result
- out_ready  input  1  consumer takes result
- p  output  P_W  result; holds its value until the next completion or reset

## Operation
- FSM states: IDLE, MUL, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and acc_in.
  - Load the accumulator with p if acc_in=1, else with 0.
  - Set idx=0, go to MUL.
- MUL:
  - Each cycle issues limb pair idx: i = idx mod NA (A limb), j = idx div NA (B limb).
  - The top limbs are zero-extended when A_W or B_W is not a multiple of LIMB_W.
  - The product is registered with shift (i+j)*LIMB_W and a pp_valid flag.
  - idx increments each cycle. After issuing idx=N-1, go to DRAIN.
- Accumulation: on every edge where pp_valid=1, acc <= acc + (pp << shift), truncated to P_W bits. The accumulator and adder are P_W bits wide; carries beyond bit P_W-1 are discarded, which only happens in MAC mode.
- DRAIN: the last product is accumulated. On the same edge, p <= final acc, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0; in_valid is ignored.
  - On out_ready=1: out_valid <= 0, go to IDLE. p keeps its value.
- MAC chaining: acc_in=1 always uses the last value driven on p, including a value that has not yet been consumed.
- Reset: state=IDLE, in_ready=1, out_valid=0, p=0, accumulator=0, pp_valid=0, idx=0.
  - Reset has priority over every other event.
  - Reset mid-operation discards the operation.
  - After reset, acc_in=1 accumulates onto 0.

## Timing
- Accepting edge = e0. Products are registered on edges e1..eN and accumulated on e2..eN+1. out_valid and p update on edge eN+1.
- Latency is N+1 cycles: 5 for the defaults (N=4).
- in_ready is 0 from the edge after acceptance until the edge after the output handshake.
- Minimum issue interval is N+3 cycles (accept, N issues, drain, handshake).
- out_valid and p are stable while out_ready=0, for any duration.
- out_ready while out_valid=0 has no effect.

## Structure
- Package mp_mult_pkg:
  - state enum (IDLE, MUL, DRAIN, DONE).
  - Function cdiv(x, y) for NA and NB.
  - Function clog2-based width of idx.
- Sub-module mp_limb_mul:
  - Registered unsigned LIMB_W×LIMB_W multiplier, output 2*LIMB_W bits.
  - Carries the pp_valid and shift sideband.
  - Kept separate so it can later be swapped for a pipelined or DSP-mapped version.
- The top module holds the FSM, idx counter, limb muxes, accumulator and output register.

## Test plan
- Defaults, a=3, b=5, acc_in=0 → p=15; out_valid rises exactly 5 cycles after the accepting edge; in_ready=0 throughout.
- a=2^131-1, b=2^128-1 → p = 2^259 - 2^131 - 2^128 + 1. This exercises the zero-extended 65-bit top A limb and full carry propagation.
- MAC: a=7, b=6, acc_in=0 → p=42. Then a=2, b=3, acc_in=1 → p=48. Then a=2^131-1, b=2^128-1, acc_in=1 → p=(2^259 - 2^131 - 2^128 + 1 + 48) mod 2^259.
- Backpressure: hold out_ready=0 for 10 cycles after completion with in_valid=1 and new a, b → out_valid and p stay stable, in_ready=0, no capture. Raise out_ready → in_ready=1 next cycle.
- Reset mid-MUL (idx=2) with a=9, b=9 → next cycle: out_valid=0, p=0, in_ready=1, and no result ever appears. Then a=1, b=1, acc_in=1 → p=1.
- Parameter variant A_W=B_W=64, LIMB_W=32 (N=4): a=b=2^64-1 → p = 2^128 - 2^65 + 1, latency 5 cycles.
